// File: rtl/bcd_convert_7.sv
// Iterative 7-bit binary to BCD converter (double-dabble) with a start/busy/done handshake
// and active-low seven-segment decode for the tens and ones digits.
module bcd_convert_7 #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [6:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [18:0] work_q, work_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // Add 3 to every BCD field of the work register that holds 5 or more.
  function automatic logic [18:0] add3(input logic [18:0] w);
    logic [18:0] r;
    r = w;
    for (int f = 0; f < 3; f++) begin
      if (w[7+4*f +: 4] >= 4'd5) r[7+4*f +: 4] = w[7+4*f +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // State register and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      work_q  <= '0;
      iter_q  <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    iter_d  = iter_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = {12'b0, bin_in};
          iter_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = add3(work_q) << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd6) state_d = StDone;
      end
      StDone: begin
        hund_d  = work_q[18:15];
        tens_d  = work_q[14:11];
        ones_d  = work_q[10:7];
        ovf_d   = (work_q[18:15] != 4'd0);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    hund     = hund_q;
    tens     = tens_q;
    ones     = ones_q;
    ovf      = ovf_q;
    seg_ones = seg7(ones_q);
    seg_tens = (BLANK_LZ && tens_q == 4'd0 && hund_q == 4'd0) ? 7'h7F : seg7(tens_q);
  end

endmodule

// File: doc/bcd_convert_7.md
# bcd_convert_7

Sequential binary-to-BCD converter that consumes the 7-bit `count_out` of the programmable counter stage and produces hundreds/tens/ones BCD digits plus active-low seven-segment patterns for a two-digit display. It runs an iterative shift-and-add-3 (double-dabble) conversion over a start/busy/done handshake. Results are held stable between conversions. It sits directly downstream of the counter and directly upstream of the display pins.

## Interface
- `BLANK_LZ`, default 1: when 1, the tens display is blanked if `tens==0` and `hund==0`.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin_in`  in  7  unsigned binary value, 0..127; captured on an accepted start.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when new results are valid.
- `hund`  out  4  BCD hundreds digit, 0 or 1.
- `tens`  out  4  BCD tens digit.
- `ones`  out  4  BCD ones digit.
- `ovf`  out  1  captured value is ≥100, so it cannot be shown on two digits.
- `seg_tens`  out  7  active-low segments {g,f,e,d,c,b,a} for `tens`.
- `seg_ones`  out  7  active-low segments {g,f,e,d,c,b,a} for `ones`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - If `start==1`: load the 19-bit work register {12'b0, `bin_in`}, set iteration counter to 0, set `busy=1`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - For each of the three 4-bit BCD fields, add 3 if the field is ≥5.
  - Then shift the whole work register left by 1 and increment the iteration counter.
  - After the 7th shift, go to DONE.
- DONE
  - Register BCD fields [18:15]→`hund`, [14:11]→`tens`, [10:7]→`ones`.
  - Set `ovf = (hund!=0)`, `done=1`, `busy=0`; go to IDLE.
- Outputs `hund/tens/ones/ovf` change only in DONE or on reset. They hold their last values otherwise.
- `seg_*` are combinational decodes of the registered digits. Patterns 0..9:
  - 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex, active-low).
  - Digit codes 10..15 decode to 7F (blank); these cannot occur in normal operation.
- Leading-zero blanking: with `BLANK_LZ==1`, `tens==0` and `hund==0`, `seg_tens` = 7F.
- `start` asserted while `busy==1` is ignored. It is not queued, and the captured `bin_in` is unaffected.
- Changes on `bin_in` after the capture edge have no effect on the conversion in progress.

## Timing
- Reset values, applied immediately on `RST` rise:
  - State IDLE; `busy=0`, `done=0`, `ovf=0`; `hund=tens=ones=0`.
  - Work register and iteration counter cleared.
  - Hence `seg_ones`=40 and `seg_tens`=7F with `BLANK_LZ=1` (40 with `BLANK_LZ=0`).
- Reset mid-conversion aborts it. No `done` pulse follows, and outputs return to reset values.
- Conversion sequence, with `start` sampled in IDLE at edge N:
  - `busy` is high after edges N through N+7.
  - Shifts occur at edges N+1..N+7.
  - Results are registered at edge N+8; `done` is high for exactly the cycle following N+8; `busy` falls at N+8.
- Latency: 8 cycles from the accepting edge to valid results.
- Throughput: the earliest next accepting edge is N+9, so one conversion per 9 cycles with `start` held high.
- `done` and `busy` are never high together.
- `done` is a single-cycle pulse even if `start` stays high.
- Arithmetic: BCD fields are 4 bits. The add-3 adjustment never overflows a field for inputs ≤127, and no carry crosses into the next field. The maximum result is `hund=1`, `tens=2`, `ones=7`.
- Boundary: `bin_in=99` gives `ovf=0`; `bin_in=100` gives `ovf=1`.

## Test plan
- Reset, then convert 0:
  - After `RST`: all outputs at reset values.
  - `start` with `bin_in=0`: `done` at N+8 with 0/0/0, `ovf=0`, `seg_ones`=40, `seg_tens`=7F.
- Values 37, 99, 100, 127, each converted separately; required `hund/tens/ones/ovf`:
  - 37 → 0/3/7/0
  - 99 → 0/9/9/0
  - 100 → 1/0/0/1
  - 127 → 1/2/7/1
  - Also check `seg_ones`/`seg_tens`: 37 gives 78/30, 99 gives 10/10.
- Start while busy:
  - `start` with 42 at edge N; `start` again with 85 at N+3.
  - Required: a single `done` at N+8 with result 0/4/2; no second conversion.
  - `bin_in` changed to 85 mid-conversion must not alter the result.
- Back-to-back:
  - `start` held high with `bin_in` stepping 5→6.
  - Required: `done` pulses exactly 9 cycles apart, yielding 5 then 6; `busy` low only in the `done` cycles.
- Async reset mid-conversion:
  - `start` with 88 at N, then assert `RST` between N+4 and N+5.
  - Required: `busy`=0 immediately, no `done`, digits 0.
  - A fresh conversion of 88 then completes normally with 0/8/8.
- `BLANK_LZ=0` instance, convert 7:
  - `seg_tens`=40 (zero shown) and `seg_ones`=78.
